mul_share_arb: RTL and testbench
================================

Name: mul_share_arb

Overview:
Shares one combinational 16x16 two's-complement multiplier (mul_tc_16_16) among NREQ requesters. The block arbitrates round-robin, captures operands, registers the 32-bit signed product and returns it on a single response channel tagged with the requester index. It sits between DSP-style clients and the shared multiplier and is the only block that drives the multiplier's a/b inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester index; must satisfy 2**IDW >= NREQ

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  bit i: requester i has operands pending
req_ready  out  NREQ  bit i: operands of requester i accepted this cycle (one-hot or zero)
req_a  in  16*NREQ  operand a, requester i at bits [16i+15:16i], signed
req_b  in  16*NREQ  operand b, same packing, signed
rsp_valid  out  1  product available
rsp_ready  in  1  consumer accepts product
rsp_id  out  IDW  index of requester that owns rsp_product
rsp_product  out  32  signed product a*b
busy  out  1  high in any state other than IDLE
ops_count  out  16  completed-operation counter (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, rr_ptr=0, operand regs=0, rsp_valid=0, rsp_id=0, rsp_product=0, req_ready=0, busy=0, ops_count=0. Deassertion is sampled synchronously; the first grant is possible on the first rising edge after release.
- FSM states: IDLE, CALC, RESP.
- IDLE: if any req_valid, grant g = first requester with req_valid set, searching rr_ptr, rr_ptr+1, ... mod NREQ. req_ready[g]=1 combinationally in that cycle only. On the edge: op_a<=req_a[g], op_b<=req_b[g], id<=g, rr_ptr<=(g+1) mod NREQ, state<=CALC. If no req_valid: stay in IDLE with req_ready=0.
- CALC: the multiplier sees op_a/op_b. On the edge: rsp_product<=product, rsp_id<=id, rsp_valid<=1, state<=RESP.
- RESP: rsp_valid=1. rsp_product and rsp_id hold stable until rsp_ready. On an edge with rsp_ready=1: rsp_valid<=0, state<=IDLE. If rsp_ready is already 1 on entry, the handshake completes on the first RESP edge.
- req_ready is 0 in CALC and RESP. No new grant is made in the same cycle as a response handshake; the next grant occurs in the following IDLE cycle.
- Latency: grant edge T -> rsp_valid high after edge T+1. Minimum issue interval is 3 cycles.
- Requester protocol: operands must be stable while req_valid=1 and until the cycle req_ready=1. Dropping req_valid without a grant is legal; nothing is captured.
- Arithmetic: full signed product, no truncation. -32768*-32768 = 0x40000000 is representable.
- Fairness: a continuously asserting requester waits at most NREQ-1 grants.
- Reset mid-operation: an in-flight operation is discarded and no response is issued.

Optional Feature:
Macro MUL_SHARE_ARB_STATS_EN.
- Defined: ops_count increments by 1 on each response handshake (rsp_valid & rsp_ready) and saturates at 16'hFFFF.
- Not defined: ops_count is tied to 0 and no counter flops exist.
- The port list is identical in both builds.

Test Plan:
- Single request: req 0 with a=16'hFFFF, b=16'h0002, rsp_ready=1 -> req_ready[0] for one cycle; rsp_valid two edges later with rsp_product=32'hFFFFFFFE, rsp_id=0.
- Extreme values, one request each: 16'h8000*16'h8000 -> 32'h40000000; 16'h7FFF*16'h8000 -> 32'hC0008000; 16'h7FFF*16'h7FFF -> 32'h3FFF0001.
- Round-robin: all 4 requesters valid continuously, distinct operands -> grant order 0,1,2,3,0; each rsp_id matches its operands' product.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_product and rsp_id stable; req_ready stays 0; completion on the first rsp_ready=1 edge.
- Reset mid-op: assert rst_n=0 in CALC -> all outputs 0 immediately; no response after release; next grant goes to requester 0.
- With MUL_SHARE_ARB_STATS_EN: 20 random ops -> ops_count=20, checked against a behavioural a*b model. Without the macro -> ops_count=0 throughout.

Source files
------------

// File: rtl/mul_share_arb.sv
// rtl/mul_share_arb.sv - round-robin sharing of one 16x16 signed multiplier among NREQ requesters
// Optional macro MUL_SHARE_ARB_STATS_EN enables the saturating completed-operation counter.

module mul_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [31:0]        rsp_product,
  output logic               busy,
  output logic [15:0]        ops_count
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t             state, next_state;
  logic [IDW-1:0]     rr_ptr, grant_id, scan_id, id_q;
  logic               grant_any, rsp_done;
  logic signed [15:0] op_a, op_b, sel_a, sel_b;
  logic signed [31:0] product;

  // The shared combinational multiplier; only op_a/op_b ever reach it.
  function automatic logic signed [31:0] mul_tc_16_16(input logic signed [15:0] a,
                                                      input logic signed [15:0] b);
    return a * b;
  endfunction

  assign product = mul_tc_16_16(op_a, op_b);

  // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    scan_id   = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_id = (int'(rr_ptr) + k >= NREQ) ? IDW'(int'(rr_ptr) + k - NREQ)
                                           : IDW'(int'(rr_ptr) + k);
      if (!grant_any && req_valid[scan_id]) begin
        grant_any = 1'b1;
        grant_id  = scan_id;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_id == IDW'(j)) begin
        sel_a = req_a[16*j +: 16];
        sel_b = req_b[16*j +: 16];
      end
    end
  end

  // Gated by rst_n so no grant is advertised while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && grant_any) req_ready[grant_id] = 1'b1;
  end

  assign rsp_done = rsp_valid && rsp_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_any) next_state = CALC;
      CALC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      id_q        <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        id_q   <= grant_id;
        rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      end
      if (state == CALC) begin
        rsp_product <= product;
        rsp_id      <= id_q;
        rsp_valid   <= 1'b1;
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef MUL_SHARE_ARB_STATS_EN
  logic [15:0] ops_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             ops_q <= '0;
    else if (rsp_done && ops_q != 16'hFFFF) ops_q <= ops_q + 16'd1;
  end

  assign ops_count = ops_q;
`else
  assign ops_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// tb/tb_mul_share_arb.sv - randomized self-checking bench for mul_share_arb
// Drives and samples at the falling edge; reference model tracks grant pointer and handshakes.

module tb_mul_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [16*NREQ-1:0] req_a, req_b;
  logic               rsp_valid, rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_product;
  logic               busy;
  logic [15:0]        ops_count;

  int n_checks = 0;
  int n_pass   = 0;
  int model_rr = 0;
  int hs_count = 0;

  always #5 clk = ~clk;

  mul_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product),
    .busy(busy), .ops_count(ops_count)
  );

  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
    int pa, pb;
    pa = $signed(a);
    pb = $signed(b);
    return 32'(pa * pb);
  endfunction

  function automatic int ref_grant(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(model_rr + k) % NREQ]) return (model_rr + k) % NREQ;
    return 0;
  endfunction

  function automatic logic [15:0] exp_ops();
`ifdef MUL_SHARE_ARB_STATS_EN
    return (hs_count > 65535) ? 16'hFFFF : 16'(hs_count);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v == NREQ'(1) << k) return k;
    return -1;
  endfunction

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
    ok = (req_ready != '0);
  endtask

  task automatic wait_rsp(output bit ok);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    ok = (rsp_valid === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b1;
    req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    #1;
    n_checks++; if (req_ready !== '0) $display("FAIL reset_req_ready: got %b exp 0", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_id !== '0) $display("FAIL reset_rsp_id: got %0d exp 0", rsp_id); else n_pass++;
    n_checks++; if (rsp_product !== 32'h0) $display("FAIL reset_rsp_product: got %h exp 0", rsp_product); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
    n_checks++; if (ops_count !== 16'h0) $display("FAIL reset_ops_count: got %h exp 0", ops_count); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; req_valid = '0; model_rr = 0; hs_count = 0;
    #1;
    n_checks++; if (busy !== 1'b0 || req_ready !== '0) $display("FAIL release_idle: busy %b ready %b exp 0/0", busy, req_ready); else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok; int g; logic [15:0] ea, eb;
    for (int r = 0; r < NREQ; r++) begin
      req_a[16*r +: 16] = 16'($urandom); req_b[16*r +: 16] = 16'($urandom);
    end
    req_valid = '1; rsp_ready = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      wait_ready(ok);
      n_checks++; if (!ok) $display("FAIL rr_grant_timeout: op %0d no req_ready", i); else n_pass++;
      g = ref_grant(req_valid);
      n_checks++; if (onehot_idx(req_ready) !== i % NREQ) $display("FAIL rr_order: op %0d ready %b exp idx %0d", i, req_ready, i % NREQ); else n_pass++;
      ea = req_a[16*g +: 16]; eb = req_b[16*g +: 16];
      model_rr = (g + 1) % NREQ;
      @(negedge clk); #1;
      req_a[16*g +: 16] = 16'($urandom); req_b[16*g +: 16] = 16'($urandom);
      wait_rsp(ok);
      n_checks++; if (!ok) $display("FAIL rr_rsp_timeout: op %0d", i); else n_pass++;
      n_checks++; if (rsp_id !== IDW'(g)) $display("FAIL rr_rsp_id: got %0d exp %0d", rsp_id, g); else n_pass++;
      n_checks++; if (rsp_product !== ref_prod(ea, eb)) $display("FAIL rr_product: got %h exp %h", rsp_product, ref_prod(ea, eb)); else n_pass++;
      hs_count++;
      @(negedge clk); #1;
    end
    req_valid = '0; #1;
  endtask

  task automatic test_single();
    req_a[15:0] = 16'hFFFF; req_b[15:0] = 16'h0002; req_valid = 4'b0001; rsp_ready = 1'b1; #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b exp 0001", req_ready); else n_pass++;
    model_rr = 1;
    @(negedge clk); req_valid = '0; #1;
    n_checks++; if (req_ready !== '0 || busy !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL single_calc: ready %b busy %b rsp_valid %b exp 0000/1/0", req_ready, busy, rsp_valid); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL single_rsp_valid: got %b exp 1", rsp_valid); else n_pass++;
    n_checks++; if (rsp_product !== 32'hFFFFFFFE) $display("FAIL single_product: got %h exp fffffffe", rsp_product); else n_pass++;
    n_checks++; if (rsp_id !== '0) $display("FAIL single_id: got %0d exp 0", rsp_id); else n_pass++;
    hs_count++;
    @(negedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_done: rsp_valid %b busy %b exp 0/0", rsp_valid, busy); else n_pass++;
    n_checks++; if (ops_count !== exp_ops()) $display("FAIL single_ops: got %0d exp %0d", ops_count, exp_ops()); else n_pass++;
  endtask

  task automatic test_extremes();
    logic [15:0] ta [3] = '{16'h8000, 16'h7FFF, 16'h7FFF};
    logic [15:0] tb [3] = '{16'h8000, 16'h8000, 16'h7FFF};
    logic [31:0] tp [3] = '{32'h40000000, 32'hC0008000, 32'h3FFF0001};
    bit ok; int r;
    for (int i = 0; i < 3; i++) begin
      r = $urandom_range(0, NREQ - 1);
      req_a[16*r +: 16] = ta[i]; req_b[16*r +: 16] = tb[i];
      req_valid = NREQ'(1) << r; rsp_ready = 1'b1; #1;
      wait_ready(ok);
      n_checks++; if (req_ready !== NREQ'(1) << r) $display("FAIL ext_ready: got %b exp idx %0d", req_ready, r); else n_pass++;
      model_rr = (r + 1) % NREQ;
      @(negedge clk); req_valid = '0; #1;
      wait_rsp(ok);
      n_checks++; if (!ok || rsp_product !== tp[i]) $display("FAIL ext_product: got %h exp %h", rsp_product, tp[i]); else n_pass++;
      n_checks++; if (rsp_id !== IDW'(r)) $display("FAIL ext_id: got %0d exp %0d", rsp_id, r); else n_pass++;
      hs_count++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    bit ok; int r, other; logic [15:0] a, b; logic [31:0] ep;
    r = $urandom_range(0, NREQ - 1); other = (r + 1) % NREQ;
    a = 16'($urandom); b = 16'($urandom); ep = ref_prod(a, b);
    req_a[16*r +: 16] = a; req_b[16*r +: 16] = b;
    req_valid = NREQ'(1) << r; rsp_ready = 1'b0; #1;
    wait_ready(ok);
    n_checks++; if (!ok) $display("FAIL bp_grant_timeout: req %0d", r); else n_pass++;
    model_rr = (r + 1) % NREQ;
    @(negedge clk); req_valid = '0; #1;
    wait_rsp(ok);
    req_valid[other] = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_product !== ep || rsp_id !== IDW'(r) || req_ready !== '0)
        $display("FAIL bp_hold: cyc %0d valid %b prod %h id %0d ready %b exp 1 %h %0d 0", i, rsp_valid, rsp_product, rsp_id, req_ready, ep, r);
      else n_pass++;
      @(negedge clk); #1;
    end
    rsp_ready = 1'b1; #1;
    n_checks++; if (req_ready !== '0) $display("FAIL bp_handshake_ready: got %b exp 0", req_ready); else n_pass++;
    hs_count++;
    @(negedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_release: rsp_valid %b exp 0", rsp_valid); else n_pass++;
    n_checks++; if (req_ready !== NREQ'(1) << ref_grant(req_valid)) $display("FAIL bp_next_grant: got %b exp idx %0d", req_ready, other); else n_pass++;
    req_valid = '0; #1;
  endtask

  task automatic test_reset_mid_op();
    bit ok; logic [15:0] a0, b0;
    req_a[63:48] = 16'($urandom); req_b[63:48] = 16'($urandom);
    req_valid = 4'b1000; rsp_ready = 1'b1; #1;
    wait_ready(ok);
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b exp 1", busy); else n_pass++;
    a0 = 16'($urandom); b0 = 16'($urandom);
    req_a[15:0] = a0; req_b[15:0] = b0;
    rst_n = 1'b0; req_valid = 4'b1001; #1;
    model_rr = 0; hs_count = 0;
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || rsp_product !== 32'h0 || rsp_id !== '0 || ops_count !== 16'h0)
      $display("FAIL mid_reset_outputs: valid %b busy %b ready %b prod %h id %0d ops %0d exp all 0", rsp_valid, busy, req_ready, rsp_product, rsp_id, ops_count);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1; #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL mid_no_rsp: rsp_valid %b exp 0", rsp_valid); else n_pass++;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL mid_first_grant: got %b exp 0001", req_ready); else n_pass++;
    model_rr = 1;
    @(negedge clk); req_valid = '0; #1;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL mid_calc_valid: got %b exp 0", rsp_valid); else n_pass++;
    wait_rsp(ok);
    n_checks++; if (!ok || rsp_id !== '0 || rsp_product !== ref_prod(a0, b0))
      $display("FAIL mid_rsp: id %0d prod %h exp 0 %h", rsp_id, rsp_product, ref_prod(a0, b0)); else n_pass++;
    hs_count++;
    @(negedge clk); #1;
  endtask

  task automatic test_stats_random();
    bit ok; int g; logic [15:0] ea, eb; logic [NREQ-1:0] mask; logic [15:0] final_exp;
    rst_n = 1'b0; req_valid = '0; #1;
    @(negedge clk); rst_n = 1'b1; model_rr = 0; hs_count = 0; #1;
    for (int i = 0; i < 20; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        req_a[16*r +: 16] = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
        req_b[16*r +: 16] = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
      end
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      req_valid = mask; rsp_ready = 1'($urandom); #1;
      wait_ready(ok);
      n_checks++; if (!ok) $display("FAIL rnd_grant_timeout: op %0d", i); else n_pass++;
      g = ref_grant(mask);
      n_checks++; if (req_ready !== NREQ'(1) << g) $display("FAIL rnd_grant: op %0d got %b exp idx %0d", i, req_ready, g); else n_pass++;
      ea = req_a[16*g +: 16]; eb = req_b[16*g +: 16];
      model_rr = (g + 1) % NREQ;
      @(negedge clk); req_valid = '0; #1;
      wait_rsp(ok);
      n_checks++; if (!ok || rsp_id !== IDW'(g)) $display("FAIL rnd_id: op %0d got %0d exp %0d", i, rsp_id, g); else n_pass++;
      n_checks++; if (rsp_product !== ref_prod(ea, eb)) $display("FAIL rnd_product: op %0d got %h exp %h", i, rsp_product, ref_prod(ea, eb)); else n_pass++;
      if (!rsp_ready) begin
        repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
        rsp_ready = 1'b1; #1;
      end
      hs_count++;
      @(negedge clk); #1;
      n_checks++; if (ops_count !== exp_ops()) $display("FAIL rnd_ops: op %0d got %0d exp %0d", i, ops_count, exp_ops()); else n_pass++;
    end
`ifdef MUL_SHARE_ARB_STATS_EN
    final_exp = 16'd20;
`else
    final_exp = 16'd0;
`endif
    n_checks++; if (ops_count !== final_exp) $display("FAIL ops_final: got %0d exp %0d", ops_count, final_exp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_extremes();
    test_backpressure();
    test_reset_mid_op();
    test_stats_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
